// File: rtl/da_mvm_engine.sv
// Bit-serial distributed-arithmetic matrix-vector engine: Y = D*X, one row per result,
// using programmable per-row, per-group partial-sum tables.
module da_mvm_engine #(
  parameter int N_IN   = 8,
  parameter int N_OUT  = 8,
  parameter int IN_W   = 8,
  parameter int COEF_W = 10,
  parameter int LUT_K  = 4,
  localparam int G      = N_IN / LUT_K,
  localparam int ACC_W  = COEF_W + $clog2(G) + IN_W,
  localparam int RW     = $clog2(N_OUT),
  localparam int CFG_AW = $clog2(N_OUT) + $clog2(G) + LUT_K
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [RW-1:0]          out_row,
  output logic                   out_last,
  output logic                   busy,
  input  logic                   cfg_we,
  input  logic [CFG_AW-1:0]      cfg_addr,
  input  logic [COEF_W-1:0]      cfg_data
);

  localparam int GB = $clog2(G);
  localparam int PW = COEF_W + GB;
  localparam int BW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int TD = 2 ** CFG_AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t                   state, state_nx;
  logic [IN_W-1:0]          x [N_IN];
  logic [RW-1:0]            row;
  logic [BW-1:0]            bit_idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] tbl [TD];
  logic signed [PW-1:0]     psum;
  logic [CFG_AW-1:0]        idx;
  logic [LUT_K-1:0]         sel;
  logic                     last_row;
  logic                     first_bit;

  assign last_row  = (row == RW'(N_OUT - 1));
  assign first_bit = (bit_idx == BW'(IN_W - 1));

  // Table is flat, addressed by {row, group, entry} exactly like cfg_addr.
  always_comb begin
    psum = '0;
    idx  = '0;
    sel  = '0;
    for (int unsigned g = 0; g < G; g++) begin
      for (int unsigned i = 0; i < LUT_K; i++)
        sel[i] = x[g*LUT_K + i][bit_idx];
      idx  = CFG_AW'((32'(row) << (GB + LUT_K)) | (g << LUT_K) | 32'(sel));
      psum = psum + PW'(tbl[idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        if (bit_idx == '0) state_nx = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = last_row ? S_IDLE : S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign out_data = acc;
  assign out_row  = row;
  assign out_last = out_valid && last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TD; k++) tbl[k] <= '0;
    end else if (state == S_IDLE && cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_IN; k++) x[k] <= '0;
      row     <= '0;
      bit_idx <= '0;
      acc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < N_IN; k++) x[k] <= in_data[k*IN_W +: IN_W];
            row     <= '0;
            bit_idx <= BW'(IN_W - 1);
          end
        end
        S_RUN: begin
          // MSB plane carries negative weight, so the row starts from -P.
          if (first_bit) acc <= -ACC_W'(psum);
          else           acc <= (acc <<< 1) + ACC_W'(psum);
          if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
        end
        S_OUT: begin
          if (out_ready && !last_row) begin
            row     <= row + RW'(1);
            bit_idx <= BW'(IN_W - 1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_da_mvm_engine.sv
// Self-checking bench for da_mvm_engine: table-driven vectors plus hand-written
// sequences for latency, back-pressure, config gating and mid-run reset.
module tb_da_mvm_engine;
  localparam int N_IN = 8, N_OUT = 8, IN_W = 8, COEF_W = 10, LUT_K = 4;
  localparam int ACC_W = 19, CFG_AW = 8, RW = 3;

  logic                  clk, rst_n;
  logic                  in_valid, in_ready;
  logic [N_IN*IN_W-1:0]  in_data;
  logic                  out_valid, out_ready;
  logic [ACC_W-1:0]      out_data;
  logic [RW-1:0]         out_row;
  logic                  out_last, busy;
  logic                  cfg_we;
  logic [CFG_AW-1:0]     cfg_addr;
  logic [COEF_W-1:0]     cfg_data;

  da_mvm_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .COEF_W(COEF_W), .LUT_K(LUT_K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int x[8]; int y0; } pvec_t;
  typedef struct { longint data; int row; bit last; } exp_t;

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  int     D[8][8];
  pvec_t  tv[6];
  int     xv[8];
  int     lat, tot, n, bad;
  longint exp3;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_row", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("row_data", longint'($signed(out_data)), mon_e.data);
        check("row_idx", longint'(out_row), longint'(mon_e.row));
        check("row_last", longint'(out_last), longint'(mon_e.last));
      end
    end
  end

  function automatic int dct_coef(input int k, input int nn);
    int cosv[9] = '{64, 63, 59, 53, 45, 36, 24, 12, 0};
    int m, s;
    if (k == 0) return 45;
    m = ((2*nn + 1) * k) % 32;
    s = 1;
    if (m > 16) m = 32 - m;
    if (m > 8) begin m = 16 - m; s = -1; end
    return s * cosv[m];
  endfunction

  function automatic longint dot(input int r, input int x[8]);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'(D[r][i]) * longint'(x[i]);
    return s;
  endfunction

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = CFG_AW'(addr); cfg_data = COEF_W'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic program_tables();
    int v;
    for (int r = 0; r < 8; r++)
      for (int g = 0; g < 2; g++)
        for (int a = 0; a < 16; a++) begin
          v = 0;
          for (int i = 0; i < 4; i++) if (a[i]) v += D[r][g*4 + i];
          cfg_write((r << 5) | (g << 4) | a, v);
        end
  endtask

  task automatic push_model(input int x[8]);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e.data = dot(r, x); e.row = r; e.last = (r == 7);
      sb.push_back(e);
    end
  endtask

  task automatic push_y0(input int y0);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e.data = (r == 0) ? longint'(y0) : 0; e.row = r; e.last = (r == 7);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int x[8]);
    int w = 0;
    for (int i = 0; i < 8; i++) in_data[i*IN_W +: IN_W] = IN_W'(x[i]);
    while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
    check("in_ready_wait", longint'(in_ready), 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic measure(output int l, output int t);
    l = -1; t = 0;
    while (!in_ready && t < 500) begin
      @(posedge clk); #1; t++;
      if (out_valid && l < 0) l = t;
    end
  endtask

  task automatic drain_check();
    check("sb_drained", longint'(sb.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_row", longint'(out_row), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_last", longint'(out_last), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Popcount tables on row 0: Y0 = sum of samples.
    for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) D[r][i] = (r == 0) ? 1 : 0;
    program_tables();
    tv[0].x = '{1, 2, 3, 4, 5, 6, 7, 8};                        tv[0].y0 = 36;
    tv[1].x = '{-128, -128, -128, -128, -128, -128, -128, -128}; tv[1].y0 = -1024;
    tv[2].x = '{127, 127, 127, 127, 127, 127, 127, 127};        tv[2].y0 = 1016;
    tv[3].x = '{1, 1, 1, 1, 0, 0, 0, 0};                        tv[3].y0 = 4;
    tv[4].x = '{-1, -1, -1, -1, -1, -1, -1, -1};                tv[4].y0 = -8;
    tv[5].x = '{100, -100, 50, -50, 0, 1, -1, 127};             tv[5].y0 = 127;
    for (int v = 0; v < 6; v++) begin
      push_y0(tv[v].y0);
      send(tv[v].x);
      measure(lat, tot);
      check("pop_latency", lat, 8);
      check("pop_total", tot, 72);
      drain_check();
    end

    // Write during RUN must be dropped; the same write in IDLE lands.
    xv = '{1, 1, 1, 1, 0, 0, 0, 0};
    push_y0(4);
    send(xv);
    repeat (2) @(posedge clk);
    #1;
    cfg_write(15, 511);
    measure(lat, tot);
    drain_check();
    cfg_write(15, 511);
    push_y0(511);
    send(xv);
    measure(lat, tot);
    check("cfg_idle_total", tot, 72);
    drain_check();

    // DCT tables, impulse in sample 0.
    for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) D[r][i] = dct_coef(r, i);
    program_tables();
    xv = '{10, 0, 0, 0, 0, 0, 0, 0};
    push_model(xv);
    send(xv);
    measure(lat, tot);
    check("dct_latency", lat, 8);
    check("dct_total", tot, 72);
    drain_check();

    // Back-pressure at row 3 for 20 cycles.
    xv = '{10, -3, 7, 20, -50, 4, 0, -1};
    exp3 = dot(3, xv);
    push_model(xv);
    send(xv);
    n = 0;
    while (!(out_valid && out_row == 3'd3) && n < 200) begin @(posedge clk); #1; n++; end
    check("stall_reach_row3", longint'(out_valid && out_row == 3'd3), 1);
    out_ready = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1; n++;
      if (!out_valid || out_row != 3'd3 || longint'($signed(out_data)) != exp3 || !busy) bad++;
    end
    check("stall_hold", bad, 0);
    out_ready = 1'b1;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    check("stall_total", n, 92);
    drain_check();

    // Asynchronous reset in RUN of row 2.
    push_model(xv);
    send(xv);
    n = 0;
    while (!(out_row == 3'd2 && busy && !out_valid) && n < 200) begin @(posedge clk); #1; n++; end
    check("reach_row2_run", longint'(out_row == 3'd2 && busy && !out_valid), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", longint'(in_ready), 1);
    check("arst_out_valid", longint'(out_valid), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_out_row", longint'(out_row), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) D[r][i] = 0;
    xv = '{10, 20, 30, 40, -50, -60, -70, 127};
    push_model(xv);
    send(xv);
    measure(lat, tot);
    check("post_rst_total", tot, 72);
    drain_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
